// File: rtl/mem_bus_pkg.sv
// Shared types and address-map constants for the CPU external memory bus target.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY,
    S_ABORT
  } state_e;

  // Wait-state counter geometry.
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  // Address map: the region is decided by the top three address bits.
  localparam int unsigned DECODE_MSB = 15;
  localparam int unsigned DECODE_LSB = 13;
  localparam logic [15:0] RAM_BASE   = 16'h8000;
  localparam logic [15:0] IO_BASE    = 16'hE000;

  // Active-low select vector ordered {io, ram, rom}; all high means nothing selected.
  localparam logic [2:0] SEL_NONE = 3'b111;

  // Region of a CPU address; IO sits above RAM, which sits above ROM.
  function automatic region_e decode_region(input logic [15:0] a);
    if (a[DECODE_MSB:DECODE_LSB] >= IO_BASE[DECODE_MSB:DECODE_LSB]) begin
      return REG_IO;
    end else if (a[DECODE_MSB:DECODE_LSB] >= RAM_BASE[DECODE_MSB:DECODE_LSB]) begin
      return REG_RAM;
    end
    return REG_ROM;
  endfunction

  // Active-low one-hot select pattern for a region.
  function automatic logic [2:0] sel_n_of(input region_e r);
    case (r)
      REG_ROM: return 3'b110;
      REG_RAM: return 3'b101;
      REG_IO:  return 3'b011;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wait_state_counter.sv
// Loadable down-counter for bus wait states; flags the last wait tick.
module wait_state_counter
  import mem_bus_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; the count saturates at zero instead of wrapping.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the CPU external memory bus: region decode, wait states,
// registered read data and a single write commit per bus cycle.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] addr,
  input  logic        n_oe_mem,
  input  logic        n_we_mem,
  input  logic [7:0]  d_from_cpu,
  output logic [7:0]  d_to_cpu,
  output logic        d_to_cpu_oe,
  output logic        n_mem_rdy,
  output logic [15:0] dev_addr,
  output logic [7:0]  dev_wdata,
  input  logic [7:0]  dev_rdata,
  output logic        n_sel_rom,
  output logic        n_sel_ram,
  output logic        n_sel_io,
  output logic        dev_n_oe,
  output logic        dev_n_we,
  output logic        bus_err
);

  // A wait count that does not fit the 4-bit counter is a configuration error.
  if ((ROM_WAIT > CNT_MAX) || (RAM_WAIT > CNT_MAX) || (IO_WAIT > CNT_MAX)) begin : g_bad_wait
    $error("mem_bus_responder: wait-state parameter exceeds 15");
  end

  localparam logic [CNT_W-1:0] ROM_N = ROM_WAIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] RAM_N = RAM_WAIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] IO_N  = IO_WAIT[CNT_W-1:0];

  state_e      state_q;
  region_e     region_q;
  logic        is_wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        rdata_oe_q;
  logic        rdy_n_q;
  logic [2:0]  sel_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        err_q;

  logic             req;
  logic             wr_d;
  logic             both_d;
  region_e          region_d;
  logic [CNT_W-1:0] wait_d;
  logic             cnt_last;
  logic             cnt_load;
  logic             cnt_dec;
  logic             enter_ready;
  logic             entry_wr;
  logic             entry_rom;

  // Decode the live strobes and address into request, direction, region and wait count.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req      = ~n_oe_mem | ~n_we_mem;
    wr_d     = ~n_we_mem;
    both_d   = ~n_oe_mem & ~n_we_mem;
    region_d = decode_region(addr);
    wait_d   = '0;
    case (region_d)
      REG_ROM: wait_d = ROM_N;
      REG_RAM: wait_d = RAM_N;
      REG_IO:  wait_d = IO_N;
      default: wait_d = '0;
    endcase
  end

  // Work out when READY is entered and which cycle attributes apply on that edge.
  always_comb begin
    enter_ready = ((state_q == S_IDLE) && req && (wait_d == '0)) ||
                  ((state_q == S_WAIT) && req && cnt_last);
    entry_wr    = (state_q == S_IDLE) ? wr_d : is_wr_q;
    entry_rom   = (state_q == S_IDLE) ? (region_d == REG_ROM) : (region_q == REG_ROM);
    cnt_load    = (state_q == S_IDLE) && req;
    cnt_dec     = (state_q == S_WAIT) && req && !cnt_last;
  end

  wait_state_counter u_wait_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (cnt_load),
    .load_val_i (wait_d),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  // Bus-cycle FSM with all CPU- and device-facing outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      region_q   <= REG_ROM;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rdata_oe_q <= 1'b0;
      rdy_n_q    <= 1'b1;
      sel_n_q    <= SEL_NONE;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      // Write pulse and error flag are single-cycle unless re-armed below.
      we_n_q <= 1'b1;
      err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q   <= addr;
            wdata_q  <= d_from_cpu;
            region_q <= region_d;
            is_wr_q  <= wr_d;
            err_q    <= both_d | (wr_d & (region_d == REG_ROM));
            sel_n_q  <= sel_n_of(region_d);
            oe_n_q   <= wr_d;
            state_q  <= (wait_d == '0) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_ABORT;
            sel_n_q <= SEL_NONE;
            oe_n_q  <= 1'b1;
          end else if (cnt_last) begin
            state_q <= S_READY;
          end
        end
        S_READY: begin
          if (!req) begin
            state_q    <= S_IDLE;
            rdy_n_q    <= 1'b1;
            rdata_oe_q <= 1'b0;
            sel_n_q    <= SEL_NONE;
            oe_n_q     <= 1'b1;
          end
        end
        S_ABORT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Completion: capture read data, or commit the write once (never to ROM).
      if (enter_ready) begin
        rdy_n_q <= 1'b0;
        if (!entry_wr) begin
          rdata_q    <= dev_rdata;
          rdata_oe_q <= 1'b1;
        end else if (!entry_rom) begin
          we_n_q <= 1'b0;
        end
      end
    end
  end

  assign d_to_cpu    = rdata_q;
  assign d_to_cpu_oe = rdata_oe_q;
  assign n_mem_rdy   = rdy_n_q;
  assign dev_addr    = addr_q;
  assign dev_wdata   = wdata_q;
  assign {n_sel_io, n_sel_ram, n_sel_rom} = sel_n_q;
  assign dev_n_oe    = oe_n_q;
  assign dev_n_we    = we_n_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT completes, commits or flags.
module tb_mem_bus_responder;

  localparam int ROM_WAIT = 1;
  localparam int RAM_WAIT = 0;
  localparam int IO_WAIT  = 3;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_BOTH = 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] addr;
  logic        n_oe_mem;
  logic        n_we_mem;
  logic [7:0]  d_from_cpu;
  logic [7:0]  d_to_cpu;
  logic        d_to_cpu_oe;
  logic        n_mem_rdy;
  logic [15:0] dev_addr;
  logic [7:0]  dev_wdata;
  logic [7:0]  dev_rdata;
  logic        n_sel_rom;
  logic        n_sel_ram;
  logic        n_sel_io;
  logic        dev_n_oe;
  logic        dev_n_we;
  logic        bus_err;

  mem_bus_responder #(
    .ROM_WAIT (ROM_WAIT),
    .RAM_WAIT (RAM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .addr        (addr),
    .n_oe_mem    (n_oe_mem),
    .n_we_mem    (n_we_mem),
    .d_from_cpu  (d_from_cpu),
    .d_to_cpu    (d_to_cpu),
    .d_to_cpu_oe (d_to_cpu_oe),
    .n_mem_rdy   (n_mem_rdy),
    .dev_addr    (dev_addr),
    .dev_wdata   (dev_wdata),
    .dev_rdata   (dev_rdata),
    .n_sel_rom   (n_sel_rom),
    .n_sel_ram   (n_sel_ram),
    .n_sel_io    (n_sel_io),
    .dev_n_oe    (dev_n_oe),
    .dev_n_we    (dev_n_we),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; edge k is the k-th posedge.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          edge_no;
    logic [15:0] a;
    bit          is_rd;
    logic [7:0]  rdata;
    logic [2:0]  sel_n;
  } rsp_t;

  typedef struct {
    int          edge_no;
    logic [15:0] a;
    logic [7:0]  wdata;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   err_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the address map: 0=ROM, 1=RAM, 2=IO.
  function automatic int region_of(input logic [15:0] a);
    if (a[15] == 1'b0) return 0;
    if (a[15:13] == 3'b111) return 2;
    return 1;
  endfunction

  function automatic int wait_of(input logic [15:0] a);
    case (region_of(a))
      0:       return ROM_WAIT;
      1:       return RAM_WAIT;
      default: return IO_WAIT;
    endcase
  endfunction

  // Expected {n_sel_io, n_sel_ram, n_sel_rom}.
  function automatic logic [2:0] sel_of(input logic [15:0] a);
    case (region_of(a))
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  // Monitor: completion, write commit and error pulses are checked against the queues.
  logic prev_rdy = 1'b1;
  logic prev_we  = 1'b1;
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    int   e;
    if (!n_mem_rdy && prev_rdy) begin
      check("rdy_expected", rsp_q.size() != 0, 1'b1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rdy_edge", edge_cnt, r.edge_no);
        check("dev_addr", dev_addr, r.a);
        check("selects", {n_sel_io, n_sel_ram, n_sel_rom}, r.sel_n);
        check("d_to_cpu_oe", d_to_cpu_oe, r.is_rd);
        check("dev_n_oe", dev_n_oe, !r.is_rd);
        if (r.is_rd) check("d_to_cpu", d_to_cpu, r.rdata);
      end
    end
    if (!dev_n_we) begin
      check("dev_n_we_width", prev_we, 1'b1);
      if (prev_we) begin
        check("commit_expected", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("commit_edge", edge_cnt, w.edge_no);
          check("commit_addr", dev_addr, w.a);
          check("commit_wdata", dev_wdata, w.wdata);
        end
      end
    end
    if (bus_err) begin
      check("bus_err_expected", err_q.size() != 0, 1'b1);
      if (err_q.size() != 0) begin
        e = err_q.pop_front();
        check("bus_err_edge", edge_cnt, e);
      end
    end
    prev_rdy <= n_mem_rdy;
    prev_we  <= dev_n_we;
  end

  // One CPU bus cycle. Called just after a negedge; abort_j >= 0 releases the
  // strobes after edge k+abort_j (must be below the region's wait count).
  task automatic do_txn(input logic [15:0] a, input int kind, input logic [7:0] wd,
                        input logic [7:0] rd, input int abort_j, input int hold, input int gap);
    int   k;
    int   n;
    bit   is_wr;
    rsp_t r;
    wr_t  w;
    addr       = a;
    d_from_cpu = wd;
    dev_rdata  = rd;
    n_oe_mem   = !(kind == K_RD || kind == K_BOTH);
    n_we_mem   = !(kind == K_WR || kind == K_BOTH);
    k     = edge_cnt + 1;
    n     = wait_of(a);
    is_wr = (kind != K_RD);
    if (kind == K_BOTH || (is_wr && region_of(a) == 0)) err_q.push_back(k);
    if (abort_j < 0) begin
      r.edge_no = k + n;
      r.a       = a;
      r.is_rd   = !is_wr;
      r.rdata   = rd;
      r.sel_n   = sel_of(a);
      rsp_q.push_back(r);
      if (is_wr && region_of(a) != 0) begin
        w.edge_no = k + n;
        w.a       = a;
        w.wdata   = wd;
        wr_q.push_back(w);
      end
    end
    @(negedge clk);
    // The cycle is latched at edge k; later bus changes must not leak through.
    addr       = 16'($urandom);
    d_from_cpu = 8'($urandom);
    if (abort_j >= 0) begin
      while (edge_cnt < k + abort_j) @(negedge clk);
      n_oe_mem = 1'b1;
      n_we_mem = 1'b1;
      @(negedge clk);
      check("abort_selects", {n_sel_io, n_sel_ram, n_sel_rom}, 3'b111);
      check("abort_rdy", n_mem_rdy, 1'b1);
      check("abort_dev_n_oe", dev_n_oe, 1'b1);
      @(negedge clk);
      repeat (gap - 1) @(negedge clk);
    end else begin
      for (int t = 0; t < 40 && n_mem_rdy; t++) @(negedge clk);
      check("rdy_seen", n_mem_rdy, 1'b0);
      dev_rdata = 8'($urandom);
      repeat (hold) @(negedge clk);
      if (!is_wr) check("d_to_cpu_held", d_to_cpu, rd);
      n_oe_mem = 1'b1;
      n_we_mem = 1'b1;
      @(negedge clk);
      check("release_rdy", n_mem_rdy, 1'b1);
      check("release_oe", d_to_cpu_oe, 1'b0);
      check("release_selects", {n_sel_io, n_sel_ram, n_sel_rom}, 3'b111);
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_d_to_cpu"}, d_to_cpu, 8'h00);
    check({tag, "_d_to_cpu_oe"}, d_to_cpu_oe, 1'b0);
    check({tag, "_n_mem_rdy"}, n_mem_rdy, 1'b1);
    check({tag, "_dev_addr"}, dev_addr, 16'h0000);
    check({tag, "_dev_wdata"}, dev_wdata, 8'h00);
    check({tag, "_selects"}, {n_sel_io, n_sel_ram, n_sel_rom}, 3'b111);
    check({tag, "_dev_n_oe"}, dev_n_oe, 1'b1);
    check({tag, "_dev_n_we"}, dev_n_we, 1'b1);
    check({tag, "_bus_err"}, bus_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int          reg_sel;
    int          kr;
    int          kind;
    int          n;
    int          ab;

    n_rst      = 1'b0;
    n_oe_mem   = 1'b1;
    n_we_mem   = 1'b1;
    addr       = '0;
    d_from_cpu = '0;
    dev_rdata  = '0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    n_rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_txn(16'h8010, K_RD, 8'h00, 8'h5A, -1, 1, 1);
    do_txn(16'hE003, K_WR, 8'hC3, 8'h00, -1, 0, 1);
    do_txn(16'h0100, K_WR, 8'h77, 8'h00, -1, 0, 1);
    do_txn(16'hE100, K_RD, 8'h00, 8'h11,  1, 0, 1);

    // Reset in the middle of an IO write's wait phase.
    addr       = 16'hE003;
    d_from_cpu = 8'hC3;
    n_we_mem   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_reset_values("mid_wait_rst");
    @(negedge clk);
    n_we_mem = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Back-to-back RAM reads with a single idle cycle between them.
    do_txn(16'h8020, K_RD, 8'h00, 8'hA1, -1, 0, 1);
    do_txn(16'h8021, K_RD, 8'h00, 8'hB2, -1, 0, 1);

    // Both strobes low: a write with a bus error.
    do_txn(16'h9000, K_BOTH, 8'h3C, 8'h00, -1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      reg_sel = $urandom_range(0, 2);
      a = 16'($urandom);
      case (reg_sel)
        0:       a[15] = 1'b0;
        1:       a[15:13] = 3'(4 + $urandom_range(0, 2));
        default: a[15:13] = 3'b111;
      endcase
      kr = $urandom_range(0, 9);
      kind = (kr < 5) ? K_RD : (kr < 9) ? K_WR : K_BOTH;
      n = wait_of(a);
      ab = -1;
      if (n > 0 && $urandom_range(0, 5) == 0) ab = $urandom_range(0, n - 1);
      do_txn(a, kind, 8'($urandom), 8'($urandom), ab, $urandom_range(0, 2), $urandom_range(1, 3));
    end

    repeat (4) @(negedge clk);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
